// File: rtl/sync_fifo_param_pkg.sv
// Shared helpers for the parameterised sync FIFO: width derivation and a
// parameter legality check evaluated at elaboration.
package fifo_pkg;

  // Default geometry, handy for benches and wrappers.
  localparam int DEF_DWIDTH = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W  = DEF_PTR_W + 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the counter can represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Depth must be a power of two so pointers wrap for free.
  function automatic bit params_ok(input int dwidth, input int depth,
                                   input int af, input int ae);
    return (dwidth >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a producer/consumer and the FIFO.
interface sync_fifo_param_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr;
  logic [DWIDTH-1:0] din;
  logic              rd;
  logic              clr_err;
  logic [DWIDTH-1:0] dout;
  logic              rd_valid;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, din, rd, clr_err,
    input  dout, rd_valid, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );

  modport slave (
    input  wr, din, rd, clr_err,
    output dout, rd_valid, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// No reset on the array or the read register.
module fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_d, rdata_q;

  // Array write port.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register only loads on an enabled read, otherwise holds.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Read data register.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, occupancy counter, flag decode, sticky errors.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

  if (!params_ok(DWIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_param: illegal DWIDTH/DEPTH/threshold combination");
  end

  logic [PTR_W-1:0]  wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              ovf_d, ovf_q, unf_d, unf_q;
  logic              rd_valid_d, rd_valid_q;
  logic              dout_zero_d, dout_zero_q;
  logic              empty, full, wr_ok, rd_ok;
  logic [DWIDTH-1:0] rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_C);
  assign wr_ok = bus.wr && !full;
  assign rd_ok = bus.rd && !empty;

  // Storage; reset suppresses both ports so nothing moves during rst.
  fifo_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clk   (clk),
    .we    (wr_ok && !rst),
    .waddr (wptr_q),
    .wdata (bus.din),
    .re    (rd_ok && !rst),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  // Next-state: pointers wrap naturally, counter tracks net transfers,
  // sticky errors give set priority over clear.
  always_comb begin
    wptr_d      = wptr_q + PTR_W'(wr_ok);
    rptr_d      = rptr_q + PTR_W'(rd_ok);
    count_d     = count_q;
    if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
    if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    ovf_d       = (bus.wr && full)  || (ovf_q && !bus.clr_err);
    unf_d       = (bus.rd && empty) || (unf_q && !bus.clr_err);
    rd_valid_d  = rd_ok;
    // The memory read register has no reset, so dout is forced to zero
    // from reset until the first accepted read reloads it.
    dout_zero_d = dout_zero_q && !rd_ok;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      dout_zero_q <= 1'b1;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      rd_valid_q  <= rd_valid_d;
      dout_zero_q <= dout_zero_d;
    end
  end

  // Status decode straight off the registered count.
  always_comb begin
    bus.dout         = dout_zero_q ? '0 : rdata;
    bus.rd_valid     = rd_valid_q;
    bus.count        = count_q;
    bus.empty        = empty;
    bus.full         = full;
    bus.almost_empty = (count_q <= AE_C);
    bus.almost_full  = (count_q >= AF_C);
    bus.overflow     = ovf_q;
    bus.underflow    = unf_q;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default geometry.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  sync_fifo_param_if #(.DWIDTH(8), .DEPTH(16)) bus ();

  sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0; bus.din = '0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_dout;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_ae",    32'(bus.almost_empty), 1);
    chk("rst_dout",  32'(bus.dout), 0);
    chk("rst_rdv",   32'(bus.rd_valid), 0);
    chk("rst_err",   32'({bus.overflow, bus.underflow}), 0);

    // 1: fill, almost_full from 12, overflow on 17th write
    for (int i = 0; i < 16; i++) begin
      bus.wr = 1'b1; bus.din = 8'(i);
      tick();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_af",    32'(bus.almost_full), 32'((i + 1) >= 12));
    end
    chk("fill_full", 32'(bus.full), 1);
    bus.din = 8'hEE;
    tick();
    chk("ovf_set",   32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 16);
    idle();

    // 2: drain in order, then underflow with dout held
    for (int i = 0; i < 16; i++) begin
      bus.rd = 1'b1;
      tick();
      chk("drain_dout",  32'(bus.dout), 32'(i));
      chk("drain_rdv",   32'(bus.rd_valid), 1);
      chk("drain_count", 32'(bus.count), 32'(15 - i));
      chk("drain_ae",    32'(bus.almost_empty), 32'((15 - i) <= 4));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    tick();
    chk("unf_set",  32'(bus.underflow), 1);
    chk("unf_rdv",  32'(bus.rd_valid), 0);
    chk("unf_dout", 32'(bus.dout), 32'h0F);
    idle();
    bus.clr_err = 1'b1;
    tick();
    chk("clr_err", 32'({bus.overflow, bus.underflow}), 0);
    idle();

    // 3: count 8, 20 cycles of simultaneous read+write across the wrap
    for (int i = 0; i < 8; i++) begin
      bus.wr = 1'b1; bus.din = 8'(8'h10 + i);
      q.push_back(8'(8'h10 + i));
      tick();
    end
    chk("rw_pre_count", 32'(bus.count), 8);
    for (int i = 0; i < 20; i++) begin
      bus.wr = 1'b1; bus.rd = 1'b1; bus.din = 8'(8'h20 + i);
      q.push_back(8'(8'h20 + i));
      exp_dout = q.pop_front();
      tick();
      chk("rw_count", 32'(bus.count), 8);
      chk("rw_dout",  32'(bus.dout), 32'(exp_dout));
    end
    idle();
    while (q.size() > 0) begin
      bus.rd = 1'b1;
      exp_dout = q.pop_front();
      tick();
      chk("rw_tail", 32'(bus.dout), 32'(exp_dout));
    end
    idle();
    chk("rw_empty", 32'(bus.empty), 1);

    // 4: empty + wr + rd -> write only, underflow, no bypass
    bus.wr = 1'b1; bus.rd = 1'b1; bus.din = 8'hA5;
    tick();
    chk("e_rw_count", 32'(bus.count), 1);
    chk("e_rw_rdv",   32'(bus.rd_valid), 0);
    chk("e_rw_unf",   32'(bus.underflow), 1);
    chk("e_rw_hold",  32'(bus.dout), 32'(exp_dout));
    idle();
    bus.rd = 1'b1;
    tick();
    chk("e_rw_dout", 32'(bus.dout), 32'hA5);
    chk("e_rw_rdv2", 32'(bus.rd_valid), 1);
    idle();

    // 5: reset mid-burst at count 9 (underflow still set, dout=A5)
    for (int i = 0; i < 9; i++) begin
      bus.wr = 1'b1; bus.din = 8'(8'h40 + i);
      tick();
    end
    chk("pre_rst_count", 32'(bus.count), 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_dout",  32'(bus.dout), 0);
    chk("mid_rst_err",   32'({bus.overflow, bus.underflow}), 0);

    // clr_err coinciding with a new overflow: set wins
    for (int i = 0; i < 16; i++) begin
      bus.wr = 1'b1; bus.din = 8'(i);
      tick();
    end
    bus.clr_err = 1'b1;
    tick();
    chk("clr_vs_ovf", 32'(bus.overflow), 1);
    idle();
    bus.clr_err = 1'b1;
    tick();
    chk("clr_alone", 32'(bus.overflow), 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
